// File: rtl/dynode_trigger_pkg.sv
// Shared constants for the dynode pulse discriminator: widths, register map, power-up values.
// Latency: n/a (package only).
// Backpressure: n/a.
package dynode_trigger_pkg;

   localparam int ADC_W = 8;
   localparam int OFF_W = 6;
   localparam int DT_W  = 6;
   localparam int BUS_W = 16;

   // Register offsets relative to the block base address
   localparam logic [15:0] REG_THRESH   = 16'd0;
   localparam logic [15:0] REG_CTRL     = 16'd1;
   localparam logic [15:0] REG_DEADTIME = 16'd2;
   localparam logic [15:0] REG_OFFSET   = 16'd3;
   localparam logic [15:0] REG_SINGLES  = 16'd4;
   localparam logic [15:0] REG_ID       = 16'd5;

   // Power-up values
   localparam logic [ADC_W-1:0] THRESH_INIT   = 8'h20;
   localparam logic [1:0]       CTRL_INIT     = 2'b01;
   localparam logic [DT_W-1:0]  DEADTIME_INIT = 6'd8;
   localparam logic [15:0]      ID_VALUE      = 16'hD71C;

endpackage

// File: rtl/dt_busreg.sv
// Generic read/write register on the shared ibus/obus register-file bus.
// Latency: write lands at the posedge with wr=1 and matching address; read is combinational.
// Backpressure: none; bus accesses always complete, obus floats when not addressed.
module dt_busreg #(
   parameter logic [15:0] ADDR = 16'h0000,
   parameter int          W    = 8,
   parameter logic [W-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [33:0]  ibus,
   output wire  [15:0]  obus,
   output logic [W-1:0] q
);

   logic        hit;
   logic        unused_bits;

   assign hit         = (ibus[31:16] == ADDR);
   // Bus clock copy (bit 33) is the same net as clk; upper write bits are beyond W
   assign unused_bits = ^{ibus[33], ibus[15:0]};

   // Capture write data when this register is addressed with wr set
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= INIT;
      else if (ibus[32] && hit)
         q <= ibus[W-1:0];
   end

   assign obus = hit ? {{(16-W){1'b0}}, q} : 16'bz;

endmodule

// File: rtl/dynode_trigger.sv
// Dynode pulse discriminator: baseline-subtracted threshold crossing with dead time and bus registers.
// Latency: sample before edge N -> single high for the cycle after edge N+1.
// Backpressure: none; one sample accepted every clock, bus reads/writes never stall.
module dynode_trigger
   import dynode_trigger_pkg::*;
#(
   parameter logic [15:0] BASE     = 16'h0030,
   parameter int          PRESCALE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [33:0]      ibus,
   output wire  [15:0]      obus,
   input  logic [ADC_W-1:0] data_in,
   output logic             single,
   output logic [OFF_W-1:0] offset
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [ADC_W-1:0] thresh;
   logic [1:0]       ctrl;
   logic [DT_W-1:0]  deadtime;

   logic [ADC_W-1:0] d1;
   logic [ADC_W:0]   diff;
   logic [ADC_W-1:0] sig;
   logic             above;
   logic             above_q;
   logic             fire;
   logic [DT_W-1:0]  dtcnt;
   logic [PS_W-1:0]  ps_cnt;
   logic             ps_term;
   logic [15:0]      singles;

   logic [15:0]      rel;
   logic             ro_sel;
   logic [15:0]      ro_dat;
   logic             singles_clr;

   dt_busreg #(.ADDR(BASE + REG_THRESH), .W(ADC_W), .INIT(THRESH_INIT)) u_thresh (
      .clk(clk), .reset(reset), .ibus(ibus), .obus(obus), .q(thresh));

   dt_busreg #(.ADDR(BASE + REG_CTRL), .W(2), .INIT(CTRL_INIT)) u_ctrl (
      .clk(clk), .reset(reset), .ibus(ibus), .obus(obus), .q(ctrl));

   dt_busreg #(.ADDR(BASE + REG_DEADTIME), .W(DT_W), .INIT(DEADTIME_INIT)) u_deadtime (
      .clk(clk), .reset(reset), .ibus(ibus), .obus(obus), .q(deadtime));

   // Baseline subtraction in 9 bits so a sample below the baseline clamps to 0
   assign diff    = {1'b0, d1} - {{(ADC_W+1-OFF_W){1'b0}}, offset};
   assign sig     = diff[ADC_W] ? '0 : diff[ADC_W-1:0];
   assign above   = (sig >= thresh);
   assign fire    = ctrl[0] && (thresh != '0) && above && !above_q && (dtcnt == '0);
   assign ps_term = (ps_cnt == PS_W'(PRESCALE - 1));

   // Sample register, edge detector, trigger output and dead-time counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d1      <= '0;
         above_q <= 1'b0;
         single  <= 1'b0;
         dtcnt   <= '0;
      end else begin
         d1      <= data_in;
         above_q <= above;
         single  <= fire;
         if (fire)
            dtcnt <= deadtime;
         else if (dtcnt != '0)
            dtcnt <= dtcnt - 1'b1;
      end
   end

   // Baseline follows quiet samples by one LSB per prescaler period
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps_cnt <= '0;
         offset <= '0;
      end else begin
         ps_cnt <= ps_term ? '0 : ps_cnt + 1'b1;
         if (ps_term && !ctrl[1] && !above) begin
            if ((d1 > {{(ADC_W-OFF_W){1'b0}}, offset}) && (offset != '1))
               offset <= offset + 1'b1;
            else if (d1 < {{(ADC_W-OFF_W){1'b0}}, offset})
               offset <= offset - 1'b1;
         end
      end
   end

   assign rel         = ibus[31:16] - BASE;
   assign singles_clr = ibus[32] && (rel == REG_SINGLES);

   // Singles counter; a bus write clears it even when a trigger fires on the same edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         singles <= '0;
      else if (singles_clr)
         singles <= '0;
      else if (fire)
         singles <= singles + 16'd1;
   end

   // Read-only register mux; RW registers drive obus from their own instances
   always_comb begin
      ro_sel = 1'b0;
      ro_dat = 16'h0000;
      case (rel)
         REG_OFFSET:  begin ro_sel = 1'b1; ro_dat = {{(16-OFF_W){1'b0}}, offset}; end
         REG_SINGLES: begin ro_sel = 1'b1; ro_dat = singles; end
         REG_ID:      begin ro_sel = 1'b1; ro_dat = ID_VALUE; end
         default:     begin ro_sel = 1'b0; ro_dat = 16'h0000; end
      endcase
   end

   assign obus = ro_sel ? ro_dat : 16'bz;

endmodule

// File: tb/tb_dynode_trigger.sv
// Directed bench for dynode_trigger: register map, baseline tracking, trigger, dead time, reset.
// Latency: expected single cycles are queued at drive time and matched by a monitor.
// Backpressure: n/a.
module tb_dynode_trigger;

   localparam logic [15:0] BASE = 16'h0030;

   logic        clk;
   logic        reset;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] wrdata;
   logic [7:0]  data_in;
   logic        single;
   logic [5:0]  offset;
   wire  [15:0] obus;
   wire  [33:0] ibus;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int exp_q[$];

   assign ibus = {clk, wr, addr, wrdata};

   dynode_trigger #(.BASE(BASE), .PRESCALE(16)) dut (
      .clk(clk), .reset(reset), .ibus(ibus), .obus(obus),
      .data_in(data_in), .single(single), .offset(offset));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [15:0] a, input logic [15:0] d);
      addr   = a;
      wrdata = d;
      wr     = 1'b1;
      tick(1);
      wr     = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      addr = a;
      wr   = 1'b0;
      #1;
      chk(tag, obus, exp);
   endtask

   // Drive a pulse of height h for w clocks then return to the quiet level
   task automatic pulse(input logic [7:0] h, input int w, input bit expect_single);
      data_in = h;
      if (expect_single) exp_q.push_back(cyc + 2);
      tick(w);
      data_in = 8'd10;
   endtask

   task automatic chk_drained(input string tag);
      chk(tag, 16'(exp_q.size()), 16'd0);
      exp_q.delete();
   endtask

   // Every observed single must match the oldest expected cycle
   initial begin
      int exp_cyc;
      forever begin
         @(posedge clk);
         #1;
         if (single === 1'b1) begin
            exp_cyc = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            n_tests++;
            assert (cyc === exp_cyc) else begin
               n_fail++;
               $error("FAIL single_timing observed_cycle=%0d expected_cycle=%0d", cyc, exp_cyc);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      wr      = 1'b0;
      addr    = 16'h0000;
      wrdata  = 16'h0000;
      data_in = 8'd10;
      #2;
      chk("reset_single", {15'b0, single}, 16'h0000);
      chk("reset_offset", {10'b0, offset}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      tick(1);

      // Power-up register values and an unmapped address
      rd_chk("pu_thresh",   BASE + 16'd0, 16'h0020);
      rd_chk("pu_ctrl",     BASE + 16'd1, 16'h0001);
      rd_chk("pu_deadtime", BASE + 16'd2, 16'h0008);
      rd_chk("pu_offset",   BASE + 16'd3, 16'h0000);
      rd_chk("pu_singles",  BASE + 16'd4, 16'h0000);
      rd_chk("pu_id",       BASE + 16'd5, 16'hD71C);
      addr = 16'h0040;
      #1;
      n_tests++;
      assert (obus === 16'hzzzz) else begin
         n_fail++;
         $error("FAIL unmapped_z observed=%h expected=zzzz", obus);
      end

      // Baseline ramps one step per 16 clocks toward the quiet level of 10
      tick(87);
      chk("baseline_mid", {10'b0, offset}, 16'd5);
      tick(80);
      chk("baseline_reach", {10'b0, offset}, 16'd10);
      tick(40);
      chk("baseline_hold", {10'b0, offset}, 16'd10);

      // Freeze keeps the baseline even with a changed quiet level
      wr_reg(BASE + 16'd1, 16'h0003);
      data_in = 8'd20;
      tick(48);
      chk("freeze_offset", {10'b0, offset}, 16'd10);
      rd_chk("freeze_offset_reg", BASE + 16'd3, 16'h000A);
      data_in = 8'd10;
      wr_reg(BASE + 16'd1, 16'h0001);
      tick(20);

      // Single trigger: one pulse, one single two clocks after the step
      pulse(8'd50, 4, 1'b1);
      tick(10);
      chk_drained("trig_seen");
      rd_chk("trig_singles", BASE + 16'd4, 16'h0001);
      chk("trig_offset", {10'b0, offset}, 16'd10);

      // Dead time: second pulse 5 clocks after the first is dropped
      wr_reg(BASE + 16'd4, 16'h0000);
      pulse(8'd50, 2, 1'b1);
      tick(3);
      pulse(8'd50, 2, 1'b0);
      tick(20);
      chk_drained("dt5_seen");
      rd_chk("dt5_singles", BASE + 16'd4, 16'h0001);

      // Dead time: 12 clocks apart gives two singles
      wr_reg(BASE + 16'd4, 16'h1234);
      pulse(8'd50, 2, 1'b1);
      tick(10);
      pulse(8'd50, 2, 1'b1);
      tick(20);
      chk_drained("dt12_seen");
      rd_chk("dt12_singles", BASE + 16'd4, 16'h0002);

      // Counter clear on the same edge as a trigger leaves it at 0
      data_in = 8'd50;
      exp_q.push_back(cyc + 2);
      tick(1);
      wr_reg(BASE + 16'd4, 16'h0000);
      tick(2);
      data_in = 8'd10;
      tick(12);
      chk_drained("clr_race_seen");
      rd_chk("clr_race_singles", BASE + 16'd4, 16'h0000);

      // Disabled and zero-threshold: pulses never trigger
      wr_reg(BASE + 16'd1, 16'h0000);
      pulse(8'd50, 4, 1'b0);
      tick(12);
      wr_reg(BASE + 16'd1, 16'h0001);
      wr_reg(BASE + 16'd0, 16'h0000);
      pulse(8'd50, 4, 1'b0);
      tick(12);
      wr_reg(BASE + 16'd0, 16'h0020);
      tick(12);
      chk_drained("disable_none");
      rd_chk("disable_singles", BASE + 16'd4, 16'h0000);

      // RW readback and a write to a read-only register
      wr_reg(BASE + 16'd2, 16'h003F);
      rd_chk("deadtime_rw", BASE + 16'd2, 16'h003F);
      wr_reg(BASE + 16'd3, 16'hFFFF);
      rd_chk("offset_ro", BASE + 16'd3, 16'h000A);

      // Asynchronous reset while single is high
      wr_reg(BASE + 16'd0, 16'h0018);
      pulse(8'd50, 2, 1'b1);
      chk("pre_reset_single", {15'b0, single}, 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      chk("async_single", {15'b0, single}, 16'h0000);
      chk("async_offset", {10'b0, offset}, 16'h0000);
      rd_chk("async_thresh",   BASE + 16'd0, 16'h0020);
      rd_chk("async_deadtime", BASE + 16'd2, 16'h0008);
      rd_chk("async_singles",  BASE + 16'd4, 16'h0000);
      data_in = 8'd10;
      @(negedge clk);
      reset = 1'b0;
      tick(3);
      chk_drained("final_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dynode_trigger.md
Name: dynode_trigger

Overview:
- Per-channel dynode pulse discriminator.
- Registers 8-bit ADC samples from the PMT dynode and tracks a 6-bit baseline (offset) during quiet periods.
- Emits a one-clock `single` pulse when the baseline-subtracted signal crosses a programmable threshold, subject to a programmable dead time.
- Sits on the shared register-file bus (ibus/obus) beside other bus slaves, which supplies configuration and a singles counter.

Parameters:
- BASE, 16'h0030, bus address of the first register; the block decodes BASE..BASE+5.
- PRESCALE, 16, clocks between baseline update steps.

Ports:
- clk  in  1  system clock; also the bus clock (ibus[33] is the same net and is ignored).
- reset  in  1  asynchronous, active-high; restores all state to power-up values.
- ibus  in  34  {clk, wr, addr[15:0], wrdata[15:0]} = bits 33, 32, 31:16, 15:0.
- obus  out  16  read data; driven only while addr is in BASE..BASE+5, otherwise 16'bz (bus is wire-shared).
- data_in  in  8  unsigned ADC sample, one per clk.
- single  out  1  one-clock trigger pulse; 0 in reset.
- offset  out  6  current baseline estimate; 0 in reset.

Behaviour:
- Registers (reads are combinational; writes occur at the posedge when wr=1 and addr matches; reset/power-up values in brackets):
  - BASE+0 THRESH, RW, 8 bits [0x20]. THRESH=0 disables triggering.
  - BASE+1 CTRL, RW, 2 bits [2'b01]. bit0 = enable; bit1 = freeze baseline.
  - BASE+2 DEADTIME, RW, 6 bits [8].
  - BASE+3 OFFSET, RO, reads {10'b0, offset}.
  - BASE+4 SINGLES, RO, 16-bit counter of emitted singles; wraps 0xFFFF->0. A write of any data clears it; clear wins over a simultaneous increment.
  - BASE+5 ID, RO, constant 16'hD71C.
  - Writes to RO addresses have no effect other than the SINGLES clear. Unused upper read bits are 0.
- Pipeline:
  - d1 <= data_in on every posedge.
  - sig = d1 - offset, computed 9 bits wide and clamped to 0 when negative.
  - above = (sig >= THRESH); above_q is above registered.
- Trigger:
  - single <= enable && THRESH!=0 && above && !above_q && dtcnt==0. This is a registered output.
  - Latency: a sample presented before edge N gives single high for exactly the cycle after edge N+1.
- Dead time:
  - On single, dtcnt <= DEADTIME.
  - Otherwise dtcnt decrements to 0 each clock, saturating.
  - Crossings while dtcnt!=0 are dropped and do not re-arm until the signal first goes below threshold.
- Baseline tracking:
  - A prescaler counts 0..PRESCALE-1. On its terminal count, if !freeze and !above, offset steps by 1 toward d1: +1 if d1>offset (saturating at 63), -1 if d1<offset (floor at 0), unchanged if equal.
  - Samples above threshold never move the baseline.
  - With THRESH=0, above is always 1, so the baseline is frozen.
- Reset mid-pulse: single drops immediately; dtcnt, above_q, prescaler, offset and counter clear; registers return to power-up values. The first cycle after reset release cannot produce single, because d1 is still 0.
- Disabling enable mid-dead-time: dtcnt keeps counting down.

Decomposition:
- Shared package dynode_trigger_pkg holds:
  - register offsets (THRESH=0 … ID=5) and power-up values;
  - ID constant;
  - ADC_W=8, OFF_W=6, DT_W=6.
- One natural sub-module: dt_busreg, a generic RW bus register with async reset and a tri-state read. Instantiate it three times. RO reads are muxed in the top level.

Test Plan:
- Power-up reads: after reset, read BASE+0..5 -> 0x0020, 0x0001, 0x0008, 0x0000, 0x0000, 0xD71C; addr 0x0040 -> obus Z.
- Baseline: data_in=10 constant, THRESH=0x20 -> offset rises 1 per 16 clocks and reaches 10 after 160 clocks, then stays; CTRL=3 (freeze) stops it.
- Trigger: baseline 10, data_in steps 10->50 for 4 clocks -> single high exactly once, two clocks after the step; SINGLES reads 1; offset unchanged.
- Dead time: DEADTIME=8, two pulses of height 50 separated by 5 clocks -> one single; separated by 12 clocks -> two singles; SINGLES=2 after the pair.
- Disable/threshold: CTRL=0 or THRESH=0 with pulses -> single never asserts; write BASE+4 -> SINGLES reads 0.
- Async reset: assert reset mid-pulse between clock edges -> single and offset go 0 immediately; THRESH returns to 0x20.
